skolem_sweep_checker: RTL and testbench

Sequential exhaustive checker that sits directly downstream of a generated combinational Skolem-function block (N universal inputs, N existential outputs). On a start request it sweeps every one of the 2^N input assignments, drives each assignment into the Skolem block, and evaluates the returned outputs against the xor-implies specification relation. It counts violations and reports pass/fail, giving the team a synthesizable, on-chip self-check for each generated Skolem netlist.

---
 rtl/skolem_chk_pkg.sv | 27 ++
 rtl/skolem_spec_eval.sv | 21 ++
 rtl/skolem_sweep_checker.sv | 139 +++++++++++++
 tb/tb_skolem_sweep_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem sweep checker.
//   state_e  : sweep FSM states (idle, sweeping, done).
//   DefaultN : default number of universal inputs / existential outputs.
//   MaxN     : widest N supported by spec_ok (narrower vectors are zero-extended).
//   spec_ok  : the xor-implies relation ok(x, y).
package skolem_chk_pkg;

  localparam int unsigned DefaultN = 8;
  localparam int unsigned MaxN     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  // ok(x, y): every x[k] implies y[k], and the XOR of all bits of {x, y} is 1.
  // Zero-extension is harmless: a 0 in x implies anything and adds nothing to parity.
  function automatic logic spec_ok(input logic [MaxN-1:0] x, input logic [MaxN-1:0] y);
    logic implies_ok;
    logic parity_ok;
    implies_ok = ((x & ~y) == '0);
    parity_ok  = ^{x, y};
    return implies_ok && parity_ok;
  endfunction

endpackage

// File: rtl/skolem_spec_eval.sv
// Combinational evaluator of the specification relation for one (x, y) pair.
// Kept as its own block so other generated benchmarks can swap in a different relation.
// Ports:
//   x_i  : assignment driven to the Skolem block
//   y_i  : Skolem block response
//   ok_o : 1 when (x_i, y_i) satisfies the relation
module skolem_spec_eval
  import skolem_chk_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic         ok_o
);

  always_comb begin
    ok_o = spec_ok(MaxN'(x_i), MaxN'(y_i));
  end

endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive on-chip checker for a combinational Skolem-function block.
// On start it drives every assignment 0 .. 2^N-1 on x_o (one per cycle), checks the
// returned y_i against the specification relation and counts violations.
// Optional feature macro: SKOLEM_CHK_FIRST_FAIL_EN adds first-violation capture ports.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start_i          : sweep request (only honoured when idle)
//   x_o / y_i        : assignment to / response from the Skolem block
//   busy_o           : sweep in progress
//   done_o           : one-cycle end-of-sweep pulse
//   pass_o           : no violations in the last sweep (held until next start)
//   fail_count_o     : number of violating assignments (0 .. 2^N)
//   first_fail_x_o   : first violating assignment      (macro only)
//   first_fail_vld_o : first_fail_x_o is valid          (macro only)
module skolem_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int unsigned N = DefaultN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  output logic [N-1:0] x_o,
  input  logic [N-1:0] y_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [N:0]   fail_count_o
`ifdef SKOLEM_CHK_FIRST_FAIL_EN
  ,
  output logic [N-1:0] first_fail_x_o,
  output logic         first_fail_vld_o
`endif
);

  localparam logic [N-1:0] CntLast = {N{1'b1}};
  localparam logic [N:0]   FailOne = (N+1)'(1);

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N:0]   fail_q, fail_d;
  logic         pass_q, pass_d;
  logic         ok;

  skolem_spec_eval #(
    .N(N)
  ) u_eval (
    .x_i  (cnt_q),
    .y_i  (y_i),
    .ok_o (ok)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSweep;
          cnt_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      StSweep: begin
        if (!ok) begin
          fail_d = fail_q + FailOne;
        end
        // Terminal test before increment, so cnt never wraps within a sweep.
        if (cnt_q == CntLast) begin
          state_d = StDone;
          pass_d  = (fail_d == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign x_o          = cnt_q;
  assign busy_o       = (state_q == StSweep);
  assign done_o       = (state_q == StDone);
  assign pass_o       = pass_q;
  assign fail_count_o = fail_q;

`ifdef SKOLEM_CHK_FIRST_FAIL_EN
  logic [N-1:0] ffx_q, ffx_d;
  logic         ffv_q, ffv_d;

  always_comb begin
    ffx_d = ffx_q;
    ffv_d = ffv_q;
    if (state_q == StIdle && start_i) begin
      ffx_d = '0;
      ffv_d = 1'b0;
    end else if (state_q == StSweep && !ok && !ffv_q) begin
      // Only the first violation of a sweep is kept.
      ffx_d = cnt_q;
      ffv_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ffx_q <= '0;
      ffv_q <= 1'b0;
    end else begin
      ffx_q <= ffx_d;
      ffv_q <= ffv_d;
    end
  end

  assign first_fail_x_o   = ffx_q;
  assign first_fail_vld_o = ffv_q;
`endif

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Randomised self-checking bench for skolem_sweep_checker (N = 8).
// The reference model works from "cycles since the accepted start" and precomputed
// violation counts over all 256 assignments; literal expectations pin the model.
module tb_skolem_sweep_checker;

  localparam int NA = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] fc;
`ifdef SKOLEM_CHK_FIRST_FAIL_EN
  logic [7:0] ffx;
  logic       ffv;
`endif

  int tests = 0;
  int fails = 0;

  int         mode = 0;
  logic [7:0] lut [NA];

  always #5 clk = ~clk;

  skolem_sweep_checker #(
    .N(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .x_o          (x),
    .y_i          (y),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .fail_count_o (fc)
`ifdef SKOLEM_CHK_FIRST_FAIL_EN
    ,
    .first_fail_x_o   (ffx),
    .first_fail_vld_o (ffv)
`endif
  );

  // Stand-in Skolem blocks selected by mode.
  function automatic logic [7:0] skolem(input int m, input logic [7:0] xv);
    logic [7:0] r;
    case (m)
      0: r = (xv == 8'hFF) ? 8'hFF : (xv | (~xv & (xv + 8'd1))); // best possible: fails only at FF
      1: r = 8'h00;
      2: r = 8'hFF;
      3: r = xv;
      4: r = xv ^ 8'h01;
      default: r = lut[xv];
    endcase
    return r;
  endfunction

  always_comb y = skolem(mode, x);

  function automatic bit ref_ok(input logic [7:0] xv, input logic [7:0] yv);
    return ((xv & ~yv) == 8'h00) && ($countones({xv, yv}) % 2 == 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k = 0 idle since reset, 1..256 sweeping x=k-1, 257 done, 258 idle after done.
  int k = 0;
  bit mvalid = 0;
  int pre [NA+1];
  int first_fail = -1;

  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      mvalid = 1;
      first_fail = -1;
      for (int i = 0; i <= NA; i++) pre[i] = 0;
    end else if (k >= 1 && k <= 257) begin
      k++;
    end else if (start) begin
      k = 1;
      first_fail = -1;
      pre[0] = 0;
      for (int i = 0; i < NA; i++) begin
        pre[i+1] = pre[i] + (ref_ok(8'(i), skolem(mode, 8'(i))) ? 0 : 1);
        if (first_fail < 0 && !ref_ok(8'(i), skolem(mode, 8'(i)))) first_fail = i;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      int idx;
      int exp_x;
      bit exp_vld;
      idx   = (k == 0) ? 0 : ((k - 1 > NA) ? NA : k - 1);
      exp_x = (k == 0) ? 0 : ((k <= 256) ? k - 1 : 255);
      chk("busy", int'(busy), (k >= 1 && k <= 256) ? 1 : 0);
      chk("done", int'(done), (k == 257) ? 1 : 0);
      chk("x", int'(x), exp_x);
      chk("fail_count", int'(fc), pre[idx]);
      chk("pass", int'(pass), (k >= 257 && pre[NA] == 0) ? 1 : 0);
      exp_vld = (first_fail >= 0) && (first_fail < idx);
`ifdef SKOLEM_CHK_FIRST_FAIL_EN
      chk("ff_vld", int'(ffv), exp_vld ? 1 : 0);
      chk("ff_x", int'(ffx), exp_vld ? first_fail : 0);
`endif
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a sweep with the given mode and wait for done; exp_fc < 0 skips literal checks.
  task automatic run_sweep(input int m, input int exp_fc, input int exp_ffx);
    bit got;
    got  = 0;
    mode = m;
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", int'(got), 1);
    if (got && exp_fc >= 0) begin
      chk("fc_literal", int'(fc), exp_fc);
      chk("pass_literal", int'(pass), (exp_fc == 0) ? 1 : 0);
`ifdef SKOLEM_CHK_FIRST_FAIL_EN
      chk("ffx_literal", int'(ffx), exp_ffx);
      chk("ffv_literal", int'(ffv), (exp_fc > 0) ? 1 : 0);
`else
      if (exp_ffx < 0) $display("note: negative first-fail literal");
`endif
    end
    @(negedge clk); // idle cycle after done
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int dones;
    bit hit;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NA; i++) lut[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fc", int'(fc), 0);

    // Directed sweeps with hand-computed totals.
    run_sweep(0, 1, 8'hFF);
    run_sweep(1, 256, 8'h00);
    run_sweep(2, 128, 8'h00);
    run_sweep(3, 256, 8'h00);
    run_sweep(4, 128, 8'h01);

    // start held high: one done per sweep, restart only from idle.
    mode  = 2;
    start = 1'b1;
    dones = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    chk("held_start_dones", dones, 2);
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy && !done) begin
        hit = 1;
        break;
      end
    end
    chk("held_start_idle", int'(hit), 1);
    @(negedge clk);

    // Reset when x_o == 8'h40, then an uninterrupted rerun.
    mode = 4;
    pulse_start();
    hit = 0;
    for (int c = 0; c < 300; c++) begin
      if (x == 8'h40 && busy) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_x40", int'(hit), 1);
    reset_cycle();
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_x", int'(x), 0);
    chk("rst_mid_done", int'(done), 0);
    repeat (3) @(negedge clk);
    run_sweep(4, 128, 8'h01);

    // rst and start together: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", int'(busy), 0);
    @(negedge clk);

    // Randomised sweeps, some interrupted by reset.
    for (int r = 0; r < 6; r++) begin
      int m;
      m = int'($urandom_range(0, 5));
      for (int i = 0; i < NA; i++) lut[i] = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        mode = m;
        pulse_start();
        repeat ($urandom_range(1, 250)) @(negedge clk);
        reset_cycle();
        @(negedge clk);
      end
      run_sweep(m, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
